// File: rtl/floppy_stepper.sv
// Floppy drive stepper tone generator: steps the head every `period` ticks,
// bouncing between track 0 and TRACKS-1. Define FLOPPY_HOME_EN to add a homing sequence after reset.
module floppy_stepper #(
  parameter int PRESCALE     = 2500,
  parameter int TRACKS       = 80,
  parameter int PULSE_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] period,
  output logic       step_n,
  output logic       dir,
  output logic [6:0] track,
  output logic       busy
);

  localparam int PW = $clog2(PRESCALE);
  localparam int CW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN
`ifdef FLOPPY_HOME_EN
    , S_HOME
`endif
  } state_t;

`ifdef FLOPPY_HOME_EN
  localparam state_t RST_STATE = S_HOME;
  localparam logic   RST_DIR   = 1'b1;
`else
  localparam state_t RST_STATE = S_IDLE;
  localparam logic   RST_DIR   = 1'b0;
`endif

  state_t          state, nstate;
  logic [PW-1:0]   pre;
  logic            tick;
  logic [7:0]      period_q;
  logic [7:0]      count;
  logic [CW-1:0]   pcnt;
  logic            run_step;
  logic            step_ev;

`ifdef FLOPPY_HOME_EN
  logic [5:0]      hcnt;
  logic [7:0]      hsteps;
  logic            home_step;
`endif

  assign tick = (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= nstate;
  end

  always_comb begin
    nstate   = state;
    run_step = 1'b0;
`ifdef FLOPPY_HOME_EN
    home_step = 1'b0;
`endif
    case (state)
      S_IDLE: if (period_q != 8'd0) nstate = S_RUN;
      S_RUN: begin
        if (period_q == 8'd0)
          nstate = S_IDLE;
        else if (tick && (({1'b0, count} + 9'd1) >= {1'b0, period_q}))
          run_step = 1'b1;
      end
`ifdef FLOPPY_HOME_EN
      S_HOME: begin
        // One pulse per 64 ticks; leave only after the final pulse has ended.
        if (tick && hcnt == 6'd63 && hsteps != 8'(TRACKS))
          home_step = 1'b1;
        if (hsteps == 8'(TRACKS) && step_n)
          nstate = S_IDLE;
      end
`endif
      default: nstate = S_IDLE;
    endcase
  end

`ifdef FLOPPY_HOME_EN
  assign step_ev = run_step | home_step;
  assign busy    = (state == S_HOME);
`else
  assign step_ev = run_step;
  assign busy    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      period_q <= '0;
      count    <= '0;
      pcnt     <= '0;
      step_n   <= 1'b1;
      track    <= '0;
      dir      <= RST_DIR;
`ifdef FLOPPY_HOME_EN
      hcnt     <= '0;
      hsteps   <= '0;
`endif
    end else begin
      pre      <= tick ? '0 : pre + PW'(1);
      period_q <= period;

      if (state == S_RUN && nstate == S_RUN) begin
        if (tick) count <= run_step ? 8'd0 : count + 8'd1;
      end else begin
        count <= 8'd0;
      end

      // Pulse runs independently of the FSM so a stop mid-pulse still completes it.
      if (step_ev) begin
        step_n <= 1'b0;
        pcnt   <= CW'(PULSE_CYCLES - 1);
      end else if (!step_n) begin
        if (pcnt == '0) step_n <= 1'b1;
        else            pcnt   <= pcnt - CW'(1);
      end

      if (run_step) begin
        if (!dir) begin
          track <= track + 7'd1;
          if (track + 7'd1 == 7'(TRACKS - 1)) dir <= 1'b1;
        end else begin
          track <= track - 7'd1;
          if (track - 7'd1 == 7'd0) dir <= 1'b0;
        end
      end

`ifdef FLOPPY_HOME_EN
      if (state == S_HOME) begin
        if (tick)      hcnt   <= hcnt + 6'd1;
        if (home_step) hsteps <= hsteps + 8'd1;
        if (nstate == S_IDLE) dir <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_floppy_stepper.sv
// Scoreboard bench for floppy_stepper: expected step events (gap, track, dir) are
// queued as stimulus is applied and matched against each falling step_n edge.
module tb_floppy_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] period;
  logic       step_n, dir, busy;
  logic [6:0] track;

  floppy_stepper #(.PRESCALE(4), .TRACKS(4), .PULSE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .period(period),
    .step_n(step_n), .dir(dir), .track(track), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap;  // 0 = spacing not checked
    int trk;
    int dr;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int gap, input int trk, input int dr);
    exp_t e;
    e.gap = gap; e.trk = trk; e.dr = dr;
    sbq.push_back(e);
  endtask

  task automatic wait_q(input int maxc, input string tag);
    int n = 0;
    while (sbq.size() != 0 && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitor: match falling edges to the scoreboard, check pulse width on rise.
  logic prev_sn = 1'b1;
  int   cyc = 0, last_fall = 0, lowcnt = 0;
  bit   skip_w = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (prev_sn === 1'b1 && step_n === 1'b0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_step", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("step_track", int'(track), e.trk);
        chk("step_dir", int'(dir), e.dr);
        if (e.gap != 0) chk("step_gap", cyc - last_fall, e.gap);
      end
      last_fall = cyc;
      lowcnt = 1;
    end else if (step_n === 1'b0) begin
      lowcnt++;
    end
    if (prev_sn === 1'b0 && step_n === 1'b1) begin
      if (!skip_w) chk("pulse_width", lowcnt, 2);
      skip_w = 1'b0;
    end
    prev_sn = step_n;
  end

  initial begin
    rst = 1'b1;
    period = 8'd0;
    idle(3);
    rst = 1'b0;
    idle(1);

`ifdef FLOPPY_HOME_EN
    chk("home_busy", int'(busy), 1);
    chk("home_dir", int'(dir), 1);
    chk("home_track", int'(track), 0);
    push(0, 0, 1);
    push(256, 0, 1);
    push(256, 0, 1);
    push(256, 0, 1);
    wait_q(2000, "home_pulses");
    begin
      int n = 0;
      while (busy && n < 20) begin idle(1); n++; end
    end
    chk("home_done_busy", int'(busy), 0);
    chk("home_done_dir", int'(dir), 0);
    chk("home_done_track", int'(track), 0);
`else
    chk("rst_step_n", int'(step_n), 1);
    chk("rst_track", int'(track), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_busy", int'(busy), 0);
`endif

    // Silent for 1000 clocks: any falling edge is flagged by the monitor.
    idle(1000);
    chk("idle_step_n", int'(step_n), 1);
    chk("idle_track", int'(track), 0);
    chk("idle_dir", int'(dir), 0);
    chk("idle_busy", int'(busy), 0);

    // period=3: a step every 12 clocks, bouncing off both ends.
    push(0, 1, 0);
    push(12, 2, 0);
    push(12, 3, 1);
    push(12, 2, 1);
    push(12, 1, 1);
    push(12, 0, 0);
    push(12, 1, 0);
    period = 8'd3;
    wait_q(200, "run_p3");

    // Just after a step, drop to period=1: steps every tick (4 clocks).
    push(4, 2, 0);
    push(4, 3, 1);
    push(4, 2, 1);
    period = 8'd1;
    wait_q(50, "run_p1");

    // Now in the first low cycle of the last pulse: stop, pulse must still finish.
    period = 8'd0;
    idle(200);
    chk("stop_step_n", int'(step_n), 1);
    chk("stop_track", int'(track), 2);
    chk("stop_dir", int'(dir), 1);

    // Reset in the middle of a pulse aborts it on the next clock.
    push(0, 1, 1);
    period = 8'd1;
    wait_q(50, "pre_rst_step");
    skip_w = 1'b1;
    rst = 1'b1;
    period = 8'd0;
    idle(1);
    chk("abort_step_n", int'(step_n), 1);
    chk("abort_track", int'(track), 0);
`ifdef FLOPPY_HOME_EN
    chk("abort_dir", int'(dir), 1);
`else
    chk("abort_dir", int'(dir), 0);
`endif
    rst = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
